// File: rtl/instr_cache_r32i_if.sv
//==============================================================================
// Module : instr_cache_r32i_if
// Brief  : Refill bus between the instruction cache and instruction memory.
//          The cache issues one beat request at a time (MemReq/MemAddr), and
//          memory answers with a one-cycle MemValid pulse carrying MemData.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface instr_cache_r32i_if #(
   parameter int dataW = 32
);
   logic             MemReq;
   logic [dataW-1:0] MemAddr;
   logic             MemValid;
   logic [dataW-1:0] MemData;

   // Cache side: drives the request, consumes the response.
   modport master (
      output MemReq,
      output MemAddr,
      input  MemValid,
      input  MemData
   );

   // Memory side: consumes the request, drives the response.
   modport slave (
      input  MemReq,
      input  MemAddr,
      output MemValid,
      output MemData
   );
endinterface

`default_nettype wire

// File: rtl/instr_cache_r32i.sv
//==============================================================================
// Module : instr_cache_r32i
// Brief  : Direct-mapped, read-only RV32I instruction cache. Zero-latency hit
//          lookup on ProgAddr; a miss stalls the PC and refills a whole line
//          beat by beat over the instr_cache_r32i_if refill bus.
//          Optional hit/miss counters are compiled in with ICACHE_STATS_EN.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module instr_cache_r32i #(
   parameter int dataW      = 32,
   parameter int LINES      = 8,
   parameter int LINE_WORDS = 4
) (
   input  wire logic             clock,
   input  wire logic             reset,
   input  wire logic [dataW-1:0] ProgAddr,
   input  wire logic             Flush,
   output logic      [dataW-1:0] Instruction,
   output logic                  InsCacheStall,
   instr_cache_r32i_if.master    mem
`ifdef ICACHE_STATS_EN
   ,
   output logic      [31:0]      HitCount,
   output logic      [31:0]      MissCount
`endif
);

   localparam int WW  = $clog2(LINE_WORDS);
   localparam int IW  = $clog2(LINES);
   localparam int OFF = WW + 2;
   localparam int TW  = dataW - OFF - IW;

   localparam logic [dataW-1:0] C_NOP = 32'h0000_0013;

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_REFILL = 1'b1;

   logic [0:0]       state_q;
   logic [WW-1:0]    beat_q;
   logic [IW-1:0]    idx_q;
   logic [TW-1:0]    tag_q;
   logic [LINES-1:0] valid_q;
   logic             flush_q;   // a flush landed during this refill

   logic [TW-1:0]    tags_q [LINES];
   logic [dataW-1:0] data_q [LINES*LINE_WORDS];

   logic [WW-1:0]    w_word;
   logic [IW-1:0]    w_idx;
   logic [TW-1:0]    w_tag;
   logic             w_hit;
   logic             w_idle;
   logic             w_fill;
   logic             w_last;
   logic             w_unused_ok;

   assign w_word      = ProgAddr[OFF-1:2];
   assign w_idx       = ProgAddr[OFF+IW-1:OFF];
   assign w_tag       = ProgAddr[dataW-1:OFF+IW];
   assign w_unused_ok = &{1'b0, ProgAddr[1:0]};

   // A same-cycle flush forces the lookup to miss.
   assign w_hit  = valid_q[w_idx] && (tags_q[w_idx] == w_tag) && !Flush;
   assign w_idle = (state_q == S_IDLE);
   assign w_fill = (state_q == S_REFILL) && mem.MemValid;
   assign w_last = w_fill && (&beat_q);

   // Lookup result and refill request, all combinational.
   always_comb begin
      InsCacheStall = !(w_idle && w_hit);
      Instruction   = InsCacheStall ? C_NOP : data_q[{w_idx, w_word}];
      mem.MemReq    = (state_q == S_REFILL);
      mem.MemAddr   = (state_q == S_REFILL) ? {tag_q, idx_q, beat_q, 2'b00} : '0;
   end

   // Control state: FSM, beat counter, latched miss address and valid bits.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         idx_q   <= '0;
         tag_q   <= '0;
         valid_q <= '0;
         flush_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (Flush) begin
                  valid_q <= '0;
               end else if (!w_hit) begin
                  // The line is about to be overwritten, so drop its old contents.
                  valid_q[w_idx] <= 1'b0;
               end
               if (!w_hit) begin
                  state_q <= S_REFILL;
                  idx_q   <= w_idx;
                  tag_q   <= w_tag;
                  beat_q  <= '0;
                  flush_q <= 1'b0;
               end
            end
            S_REFILL: begin
               if (Flush) begin
                  valid_q <= '0;
                  flush_q <= 1'b1;
               end
               if (mem.MemValid) begin
                  beat_q <= beat_q + 1'b1;
               end
               if (w_last) begin
                  state_q <= S_IDLE;
                  // A flushed refill still completes, but the line stays invalid.
                  if (!Flush && !flush_q) begin
                     valid_q[idx_q] <= 1'b1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Line storage; written only by refill beats, never reset.
   always_ff @(posedge clock) begin
      if (w_fill) begin
         data_q[{idx_q, beat_q}] <= mem.MemData;
      end
      if (w_last) begin
         tags_q[idx_q] <= tag_q;
      end
   end

`ifdef ICACHE_STATS_EN
   // Saturating hit and miss counters, sampled on IDLE lookups.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         HitCount  <= '0;
         MissCount <= '0;
      end else if (w_idle) begin
         if (w_hit && (HitCount != 32'hFFFF_FFFF)) begin
            HitCount <= HitCount + 32'd1;
         end
         if (!w_hit && (MissCount != 32'hFFFF_FFFF)) begin
            MissCount <= MissCount + 32'd1;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_cache_r32i.sv
//==============================================================================
// Module : tb_instr_cache_r32i
// Brief  : Self-checking bench for instr_cache_r32i. Keeps a line-level model
//          of the cache contents (valid/tag per index) and a hashed memory
//          image, and drives directed plus randomized fetch sequences.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_instr_cache_r32i;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] ProgAddr;
   logic        Flush;
   wire  [31:0] Instruction;
   wire         InsCacheStall;
`ifdef ICACHE_STATS_EN
   wire  [31:0] HitCount;
   wire  [31:0] MissCount;
`endif

   instr_cache_r32i_if #(.dataW(32)) mem_if ();

   instr_cache_r32i #(.dataW(32), .LINES(8), .LINE_WORDS(4)) dut (
      .clock         (clock),
      .reset         (reset),
      .ProgAddr      (ProgAddr),
      .Flush         (Flush),
      .Instruction   (Instruction),
      .InsCacheStall (InsCacheStall),
      .mem           (mem_if.master)
`ifdef ICACHE_STATS_EN
      ,
      .HitCount      (HitCount),
      .MissCount     (MissCount)
`endif
   );

   always #5 clock = ~clock;

   int          checks = 0;
   int          passes = 0;
   logic [31:0] seed;

   // Line-level model: which tag each index holds, if any.
   logic [7:0]  ref_valid;
   logic [24:0] ref_tag [8];

   function automatic logic [31:0] memw(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return (w * 32'h9E37_79B1) ^ seed ^ {w[15:0], w[31:16]};
   endfunction

   function automatic bit ref_hit(input logic [31:0] a);
      return ref_valid[a[6:4]] && (ref_tag[a[6:4]] == a[31:7]);
   endfunction

   // Fetch that the model says hits: checked combinationally, then one edge.
   task automatic hit_cycle(input logic [31:0] a, input string name);
      ProgAddr = a;
      #1;
      checks++;
      if ({InsCacheStall, Instruction, mem_if.MemReq} !== {1'b0, memw(a), 1'b0})
         $display("FAIL %s addr=%h: got stall/instr/req=%b/%h/%b expected 0/%h/0",
                  name, a, InsCacheStall, Instruction, mem_if.MemReq, memw(a));
      else passes++;
      @(posedge clock); #1;
   endtask

   // Full miss + refill. gap range sets memory latency per beat; flush_at=-2
   // flushes in the miss-detect cycle, 0..3 flushes alongside that beat.
   task automatic do_refill(input logic [31:0] a, input int gmin, input int gmax,
                            input int flush_at);
      logic [31:0] base;
      int          gap;
      bit          fl;
      base = {a[31:4], 4'h0};
      fl   = 1'b0;
      ProgAddr = a;
      Flush    = (flush_at == -2);
      #1;
      checks++;
      if ({InsCacheStall, Instruction, mem_if.MemReq} !== {1'b1, NOP, 1'b0})
         $display("FAIL miss_detect addr=%h: got stall/instr/req=%b/%h/%b expected 1/%h/0",
                  a, InsCacheStall, Instruction, mem_if.MemReq, NOP);
      else passes++;
      @(posedge clock); #1;
      Flush = 1'b0;
      if (flush_at == -2) ref_valid = '0;
      for (int b = 0; b < 4; b++) begin
         gap = $urandom_range(gmax, gmin);
         repeat (gap) begin
            checks++;
            if ({mem_if.MemReq, mem_if.MemAddr, InsCacheStall, Instruction} !==
                {1'b1, base + 32'(4*b), 1'b1, NOP})
               $display("FAIL refill_wait beat=%0d: got req/addr/stall/instr=%b/%h/%b/%h expected 1/%h/1/%h",
                        b, mem_if.MemReq, mem_if.MemAddr, InsCacheStall, Instruction,
                        base + 32'(4*b), NOP);
            else passes++;
            @(posedge clock); #1;
         end
         mem_if.MemValid = 1'b1;
         mem_if.MemData  = memw(base + 32'(4*b));
         if (b == flush_at) begin
            Flush = 1'b1;
            fl    = 1'b1;
         end
         #1;
         checks++;
         if ({mem_if.MemReq, mem_if.MemAddr, InsCacheStall, Instruction} !==
             {1'b1, base + 32'(4*b), 1'b1, NOP})
            $display("FAIL refill_beat beat=%0d: got req/addr/stall/instr=%b/%h/%b/%h expected 1/%h/1/%h",
                     b, mem_if.MemReq, mem_if.MemAddr, InsCacheStall, Instruction,
                     base + 32'(4*b), NOP);
         else passes++;
         @(posedge clock); #1;
         mem_if.MemValid = 1'b0;
         mem_if.MemData  = $urandom;
         Flush           = 1'b0;
      end
      if (fl) begin
         ref_valid = '0;
      end else begin
         ref_valid[a[6:4]] = 1'b1;
         ref_tag[a[6:4]]   = a[31:7];
      end
      #1;
      checks++;
      if (ref_hit(a)) begin
         if ({InsCacheStall, Instruction, mem_if.MemReq} !== {1'b0, memw(a), 1'b0})
            $display("FAIL post_refill addr=%h: got stall/instr/req=%b/%h/%b expected 0/%h/0",
                     a, InsCacheStall, Instruction, mem_if.MemReq, memw(a));
         else passes++;
      end else begin
         if ({InsCacheStall, Instruction, mem_if.MemReq} !== {1'b1, NOP, 1'b0})
            $display("FAIL post_refill_flushed addr=%h: got stall/instr/req=%b/%h/%b expected 1/%h/0",
                     a, InsCacheStall, Instruction, mem_if.MemReq, NOP);
         else passes++;
      end
   endtask

   task automatic test_reset();
      reset           = 1'b1;
      Flush           = 1'b0;
      ProgAddr        = 32'h10;
      mem_if.MemValid = 1'b0;
      mem_if.MemData  = '0;
      ref_valid       = '0;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if ({mem_if.MemReq, mem_if.MemAddr, InsCacheStall, Instruction} !== {1'b0, 32'h0, 1'b1, NOP})
         $display("FAIL reset_state: got req/addr/stall/instr=%b/%h/%b/%h expected 0/0/1/%h",
                  mem_if.MemReq, mem_if.MemAddr, InsCacheStall, Instruction, NOP);
      else passes++;
`ifdef ICACHE_STATS_EN
      checks++;
      if ({HitCount, MissCount} !== 64'h0)
         $display("FAIL reset_stats: got hit/miss=%0d/%0d expected 0/0", HitCount, MissCount);
      else passes++;
`endif
      reset = 1'b0;
   endtask

   task automatic test_cold_miss();
      do_refill(32'h10, 0, 0, -1);
   endtask

   task automatic test_line_hits();
      hit_cycle(32'h14, "line_hit");
      hit_cycle(32'h18, "line_hit");
      hit_cycle(32'h1C, "line_hit");
`ifdef ICACHE_STATS_EN
      checks++;
      if ({HitCount, MissCount} !== {32'd3, 32'd1})
         $display("FAIL stats_after_hits: got hit/miss=%0d/%0d expected 3/1", HitCount, MissCount);
      else passes++;
`endif
   endtask

   task automatic test_conflict();
      do_refill(32'h90, 0, 2, -1);
      hit_cycle(32'h9C, "conflict_hit");
      do_refill(32'h10, 0, 2, -1);
   endtask

   task automatic test_slow_memory();
      do_refill(32'h24, 4, 4, -1);
   endtask

   task automatic test_flush_mid_refill();
      do_refill(32'h90, 0, 1, 2);
      do_refill(32'h90, 0, 1, -1);
      do_refill(32'h24, 0, 1, -1);
   endtask

   task automatic test_flush_idle();
      hit_cycle(32'h28, "pre_flush_hit");
      do_refill(32'h28, 0, 1, -2);
      do_refill(32'h94, 0, 1, -1);
   endtask

   task automatic test_reset_mid_refill();
      ProgAddr = 32'h44;
      #1;
      @(posedge clock); #1;
      mem_if.MemValid = 1'b1;
      mem_if.MemData  = 32'hDEAD_BEEF;
      @(posedge clock); #1;
      mem_if.MemValid = 1'b0;
      reset = 1'b1;
      #1;
      checks++;
      if ({mem_if.MemReq, mem_if.MemAddr, InsCacheStall, Instruction} !== {1'b0, 32'h0, 1'b1, NOP})
         $display("FAIL reset_mid_refill: got req/addr/stall/instr=%b/%h/%b/%h expected 0/0/1/%h",
                  mem_if.MemReq, mem_if.MemAddr, InsCacheStall, Instruction, NOP);
      else passes++;
      ref_valid       = '0;
      ProgAddr        = 32'h90;
      mem_if.MemValid = 1'b1;
      mem_if.MemData  = 32'hBAD0_BAD0;
      @(posedge clock); #1;
      mem_if.MemValid = 1'b0;
      reset           = 1'b0;
      do_refill(32'h90, 0, 1, -1);
      do_refill(32'h44, 0, 1, -1);
      hit_cycle(32'h4C, "after_reset_hit");
   endtask

   task automatic test_random();
      logic [31:0] a;
      for (int i = 0; i < 40; i++) begin
         a = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4) |
             (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         if (ref_hit(a))
            hit_cycle(a, "random_hit");
         else
            do_refill(a, 0, 2, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1);
      end
   endtask

   initial begin
      seed = $urandom;
      test_reset();
      test_cold_miss();
      test_line_hits();
      test_conflict();
      test_slow_memory();
      test_flush_mid_refill();
      test_flush_idle();
      test_reset_mid_refill();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

`default_nettype wire
